s_axis_cc_adapt: RTL and testbench
==================================

// Module: s_axis_cc_adapt
// PURPOSE
//  Completer-completion (CC) adapter, the transmit-side counterpart of the CQ request adapter.
//  - Accepts completion TLPs in legacy 7-series AXI-TLP format (128-bit, 3DW header) from the
//    LitePCIe completer.
//  - Rewrites the header into the UltraScale CC descriptor and drives the hard block's
//    s_axis_cc interface.
//  - Both formats put the first payload DW in DW3, so payload passes beat-for-beat.
//  - Adds a 2-entry skid buffer and drops unsupported TLP types.
// PARAMETERS
//  DATA_WIDTH  128            datapath width; only 128 is supported
//  KEEP_WIDTH  DATA_WIDTH/8   legacy byte-keep width (16)
// PORTS
//  user_clk            in   1    core user clock
//  user_reset_n        in   1    asynchronous, active-low reset
//  s_axis_cc_tdata     in   128  legacy TLP data (DW0 at [31:0])
//  s_axis_cc_tkeep     in   16   legacy byte keep
//  s_axis_cc_tlast     in   1    legacy end of packet
//  s_axis_cc_tuser     in   4    [1] error-forward (poison), [3] discontinue, others ignored
//  s_axis_cc_tvalid    in   1    legacy valid
//  s_axis_cc_tready    out  1    legacy ready
//  s_axis_cc_tdata_a   out  128  CC descriptor/data to hard block
//  s_axis_cc_tkeep_a   out  4    dword keep
//  s_axis_cc_tlast_a   out  1    end of packet
//  s_axis_cc_tuser_a   out  33   [0] discontinue, [32:1] parity = 0
//  s_axis_cc_tvalid_a  out  1    valid to hard block
//  s_axis_cc_tready_a  in   4    hard-block ready; only bit 0 is used
//  cc_drop_cnt         out  16   saturating count of dropped TLPs
// BEHAVIOUR
//  Reset (user_reset_n=0, async):
//  - Buffer empty; FSM in SOP; cc_drop_cnt=0.
//  - s_axis_cc_tvalid_a=0, s_axis_cc_tready=0; all other outputs 0.
//  FSM (advances only on an input handshake, s_axis_cc_tvalid & s_axis_cc_tready):
//  - SOP: decode {fmt,type}=DW0[30:24].
//    - Accepted: 0x0A Cpl, 0x4A CplD, 0x0B CplLk, 0x4B CplDLk.
//    - Accepted + tlast -> SOP. Accepted + !tlast -> FWD.
//    - Other type: cc_drop_cnt += 1, saturating at 0xFFFF. Then tlast -> SOP, else DROP.
//  - FWD: beats forwarded unchanged; tlast -> SOP.
//  - DROP: beats consumed, not written to the buffer; tlast -> SOP.
//  SOP beat remap (legacy field -> descriptor bit):
//  - DW2[6:0] lower addr -> [6:0]; AT [9:8] = 0.
//  - byte count [28:16] = (DW1[11:0]==0) ? 4096 : DW1[11:0]  (13-bit).
//  - [29] locked-read completion = type[0].
//  - dword count [42:32] = fmt[1] ? (DW0[9:0]==0 ? 1024 : DW0[9:0]) : 0.
//  - [45:43] = DW1[15:13] status; [46] = DW0[14] EP | tuser[1]; [63:48] = DW2[31:16] req ID.
//  - [71:64] = DW2[15:8] tag; [87:72] = DW1[31:16] completer ID; [88] = 0.
//  - [91:89] = DW0[22:20] TC; [94:92] = {1'b0, DW0[13:12]} attr; [95] force ECRC = 0.
//  - [127:96] = DW3 unchanged.
//  Non-SOP beats:
//  - tdata passes unchanged.
//  - tkeep_a[i] = tkeep[4i], i = 0..3.
//  - tuser_a[0] = tuser[3] on every beat.
//  Skid buffer:
//  - 2 entries; output is always registered; latency is exactly 1 cycle when not stalled.
//  - s_axis_cc_tready = !full (fewer than 2 entries), registered. It stays high in DROP unless full.
//  - Output pops on s_axis_cc_tvalid_a & s_axis_cc_tready_a[0].
//  - Simultaneous push and pop keeps occupancy unchanged.
//  - Output fields are stable while tvalid_a=1 and tready_a[0]=0 (AXI-Stream).
//  - No bubbles: back-to-back packets stream at 1 beat/cycle when tready_a[0]=1.
//  Reset mid-packet:
//  - Buffered beats are discarded; no partial tlast is produced.
//  - The first legacy beat after release is treated as SOP.
// TESTING
//  1. CplD, len=1, bc=4, laddr=0x10, tag=0x2A, req=0x0100, cpl=0x0200, data 0xDEADBEEF, tlast
//     -> one beat 1 cycle later: DW0=0x0004_0010, DW1=0x0100_0001, DW2=0x0002_002A,
//        DW3=0xDEADBEEF; tkeep_a=4'hF, tlast_a=1.
//  2. CplD, len=8, bc=32, 3 beats, tready_a[0] toggled 1010...
//     -> descriptor DWcount=8, ByteCount=32; 3 beats in order, none lost or duplicated.
//     -> last tkeep_a=4'h7 (from tkeep=16'h0FFF); tready falls only when the buffer holds 2 entries.
//  3. Cpl, status=UR (3'b001), len=0, bc=0
//     -> DWcount=0, ByteCount=4096, status field 3'b001, locked=0.
//  4. CplDLk, len=0 (1024 DW), with tuser[1]=1
//     -> DWcount=1024, locked bit [29]=1, poison bit [46]=1.
//  5. MWr TLP (fmt/type 0x40), 3 beats, then a CplD
//     -> tvalid_a never asserts for the MWr; cc_drop_cnt=1; the CplD is forwarded intact.
//  6. Assert user_reset_n=0 after beat 2 of a 4-beat CplD, release, send scenario-1 TLP
//     -> tvalid_a drops with no tlast; the next output is exactly the scenario-1 beat.

Source files
------------

// File: rtl/s_axis_cc_adapt.sv
// s_axis_cc_adapt
//   Completer-completion adapter. It takes completion TLPs in the legacy
//   128-bit, 3DW-header AXI-TLP format and turns the first beat of each one
//   into an UltraScale CC descriptor. In both formats the first payload DW
//   sits in DW3, so payload beats pass through one for one. Packets that are
//   not completions are consumed and counted, and never reach the output.
//   A 2-entry skid buffer registers the output side.
//
// Ports
//   user_clk, user_reset_n         clock, asynchronous active-low reset
//   s_axis_cc_t{data,keep,last,user,valid} / s_axis_cc_tready
//                                  legacy TLP stream in (tuser[1] poison,
//                                  tuser[3] discontinue)
//   s_axis_cc_t{data,keep,last,user,valid}_a / s_axis_cc_tready_a
//                                  CC stream to the hard block (tkeep is per
//                                  DW, tuser[0] discontinue, only tready[0]
//                                  is used)
//   cc_drop_cnt                    saturating count of dropped TLPs
module s_axis_cc_adapt #(
  parameter int DATA_WIDTH = 128,  // only 128 is supported
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic                  s_axis_cc_tlast,
  input  logic [3:0]            s_axis_cc_tuser,
  input  logic                  s_axis_cc_tvalid,
  output logic                  s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
  output logic [3:0]            s_axis_cc_tkeep_a,
  output logic                  s_axis_cc_tlast_a,
  output logic [32:0]           s_axis_cc_tuser_a,
  output logic                  s_axis_cc_tvalid_a,
  input  logic [3:0]            s_axis_cc_tready_a,
  output logic [15:0]           cc_drop_cnt
);

  typedef enum logic [1:0] {ST_SOP = 2'd0, ST_FWD = 2'd1, ST_DROP = 2'd2} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            keep;
    logic                  last;
    logic                  disc;
  } beat_t;

  state_e                state_q, state_d;
  beat_t                 head_q, head_d, tail_q, tail_d, in_beat;
  logic [1:0]            cnt_q, cnt_d;
  logic                  tready_q, tready_d, tvalid_q, tvalid_d;
  logic [15:0]           drop_q, drop_d;
  logic                  in_hs, pop, push, drop_inc, type_ok;
  logic [6:0]            fmt_type;
  logic [3:0]            keep_dw;
  logic [31:0]           dw0, dw1, dw2, dw3;
  logic [12:0]           byte_cnt;
  logic [10:0]           dw_cnt;
  logic [DATA_WIDTH-1:0] sop_desc;
  logic                  unused_bits;

  assign dw0      = s_axis_cc_tdata[31:0];
  assign dw1      = s_axis_cc_tdata[63:32];
  assign dw2      = s_axis_cc_tdata[95:64];
  assign dw3      = s_axis_cc_tdata[127:96];
  assign fmt_type = dw0[30:24];
  assign type_ok  = fmt_type inside {7'h0A, 7'h4A, 7'h0B, 7'h4B};
  assign in_hs    = s_axis_cc_tvalid & tready_q;
  assign pop      = tvalid_q & s_axis_cc_tready_a[0];

  // Byte-keep collapses to dword-keep: the legacy stream only ever keeps
  // whole DWs, so the lowest byte of each DW is representative.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_keep
      assign keep_dw[gi] = s_axis_cc_tkeep[4*gi];
    end
  endgenerate

  // A zero length field encodes the maximum in both byte and DW counts;
  // the descriptor widens each field by one bit to hold that maximum.
  assign byte_cnt = (dw1[11:0] == 12'd0) ? 13'd4096 : {1'b0, dw1[11:0]};
  assign dw_cnt   = !dw0[30]             ? 11'd0 :
                    (dw0[9:0] == 10'd0)  ? 11'd1024 : {1'b0, dw0[9:0]};

  always_comb begin
    sop_desc          = '0;
    sop_desc[6:0]     = dw2[6:0];                          // lower address
    sop_desc[28:16]   = byte_cnt;
    sop_desc[29]      = dw0[24];                           // locked-read completion
    sop_desc[42:32]   = dw_cnt;
    sop_desc[45:43]   = dw1[15:13];                        // completion status
    sop_desc[46]      = dw0[14] | s_axis_cc_tuser[1];      // poisoned
    sop_desc[63:48]   = dw2[31:16];                        // requester ID
    sop_desc[71:64]   = dw2[15:8];                         // tag
    sop_desc[87:72]   = dw1[31:16];                        // completer ID
    sop_desc[91:89]   = dw0[22:20];                        // traffic class
    sop_desc[94:92]   = {1'b0, dw0[13:12]};                // attributes
    sop_desc[127:96]  = dw3;                               // first payload DW
  end

  always_comb begin
    in_beat.data = (state_q == ST_SOP) ? sop_desc : s_axis_cc_tdata;
    in_beat.keep = keep_dw;
    in_beat.last = s_axis_cc_tlast;
    in_beat.disc = s_axis_cc_tuser[3];
  end

  // Packet FSM: decides per input beat whether it is written to the buffer.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    drop_inc = 1'b0;
    if (in_hs) begin
      case (state_q)
        ST_SOP: begin
          if (type_ok) begin
            push    = 1'b1;
            state_d = s_axis_cc_tlast ? ST_SOP : ST_FWD;
          end else begin
            drop_inc = 1'b1;
            state_d  = s_axis_cc_tlast ? ST_SOP : ST_DROP;
          end
        end
        ST_FWD: begin
          push = 1'b1;
          if (s_axis_cc_tlast) state_d = ST_SOP;
        end
        ST_DROP: begin
          if (s_axis_cc_tlast) state_d = ST_SOP;
        end
        default: state_d = ST_SOP;
      endcase
    end
  end

  assign drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

  // Skid buffer: head drives the outputs, tail only fills while the head is
  // stalled. A push is only possible with fewer than two entries, because
  // tready is the registered "not full" flag.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_beat;
        else               tail_d = in_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_beat;
        end else begin
          head_d = in_beat;
        end
      end
      default: ;
    endcase
    tready_d = (cnt_d != 2'd2);
    tvalid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q  <= ST_SOP;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= 2'd0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      drop_q   <= drop_d;
    end
  end

  assign s_axis_cc_tready   = tready_q;
  assign s_axis_cc_tvalid_a = tvalid_q;
  assign s_axis_cc_tdata_a  = head_q.data;
  assign s_axis_cc_tkeep_a  = head_q.keep;
  assign s_axis_cc_tlast_a  = head_q.last;
  assign s_axis_cc_tuser_a  = {32'd0, head_q.disc};  // parity is not generated
  assign cc_drop_cnt        = drop_q;

  // Inputs that the CC format has no use for.
  assign unused_bits = ^{s_axis_cc_tready_a[3:1], s_axis_cc_tuser[2], s_axis_cc_tuser[0],
                         s_axis_cc_tkeep};

endmodule

// File: tb/tb_s_axis_cc_adapt.sv
module tb_s_axis_cc_adapt;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic [32:0]  user;
  } beat_t;

  logic         user_clk = 1'b0;
  logic         user_reset_n = 1'b0;
  logic [127:0] s_axis_cc_tdata = '0;
  logic [15:0]  s_axis_cc_tkeep = '0;
  logic         s_axis_cc_tlast = 1'b0;
  logic [3:0]   s_axis_cc_tuser = '0;
  logic         s_axis_cc_tvalid = 1'b0;
  logic         s_axis_cc_tready;
  logic [127:0] s_axis_cc_tdata_a;
  logic [3:0]   s_axis_cc_tkeep_a;
  logic         s_axis_cc_tlast_a;
  logic [32:0]  s_axis_cc_tuser_a;
  logic         s_axis_cc_tvalid_a;
  logic [3:0]   s_axis_cc_tready_a = 4'hF;
  logic [15:0]  cc_drop_cnt;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    in_cnt = 0;
  int    out_cnt = 0;
  bit    in_pend = 1'b0;
  bit    out_pend = 1'b0;
  beat_t cap_q[$];
  int    cap_cyc[$];

  // Scenario-1 vector and its expected descriptor beat.
  localparam logic [127:0] S1_IN  = {32'hDEADBEEF, 32'h01002A10, 32'h02000004, 32'h4A000001};
  localparam logic [127:0] S1_OUT = {32'hDEADBEEF, 32'h0002002A, 32'h01000001, 32'h00040010};

  always #5 user_clk = ~user_clk;

  s_axis_cc_adapt #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) dut (
    .user_clk           (user_clk),
    .user_reset_n       (user_reset_n),
    .s_axis_cc_tdata    (s_axis_cc_tdata),
    .s_axis_cc_tkeep    (s_axis_cc_tkeep),
    .s_axis_cc_tlast    (s_axis_cc_tlast),
    .s_axis_cc_tuser    (s_axis_cc_tuser),
    .s_axis_cc_tvalid   (s_axis_cc_tvalid),
    .s_axis_cc_tready   (s_axis_cc_tready),
    .s_axis_cc_tdata_a  (s_axis_cc_tdata_a),
    .s_axis_cc_tkeep_a  (s_axis_cc_tkeep_a),
    .s_axis_cc_tlast_a  (s_axis_cc_tlast_a),
    .s_axis_cc_tuser_a  (s_axis_cc_tuser_a),
    .s_axis_cc_tvalid_a (s_axis_cc_tvalid_a),
    .s_axis_cc_tready_a (s_axis_cc_tready_a),
    .cc_drop_cnt        (cc_drop_cnt)
  );

  // Handshakes are observed on the falling edge; they complete on the next rising edge.
  always @(negedge user_clk) begin
    in_pend  = s_axis_cc_tvalid && s_axis_cc_tready;
    out_pend = s_axis_cc_tvalid_a && s_axis_cc_tready_a[0];
    if (out_pend) begin
      cap_q.push_back({s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a});
      cap_cyc.push_back(cyc);
      $display("[%0t] out beat data=%h keep=%h last=%b user=%h", $time, s_axis_cc_tdata_a,
               s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a);
    end
  end

  always @(posedge user_clk) begin
    cyc++;
    if (in_pend)  in_cnt++;
    if (out_pend) out_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                           input logic [3:0] u);
    bit ok = 1'b0;
    s_axis_cc_tdata  = d;
    s_axis_cc_tkeep  = k;
    s_axis_cc_tlast  = l;
    s_axis_cc_tuser  = u;
    s_axis_cc_tvalid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge user_clk);
      if (s_axis_cc_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout: tready got 0 required 1");
    end
    $display("[%0t] in beat data=%h keep=%h last=%b user=%h", $time, d, k, l, u);
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_cc_tvalid = 1'b0;
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic test_reset();
    user_reset_n = 1'b0;
    repeat (3) @(negedge user_clk);
    n_cmp++;
    if ({s_axis_cc_tvalid_a, s_axis_cc_tready, s_axis_cc_tlast_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl: valid_a/ready/last_a got %b%b%b required 000",
               s_axis_cc_tvalid_a, s_axis_cc_tready, s_axis_cc_tlast_a);
    end
    n_cmp++;
    if ({s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tuser_a, cc_drop_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: data_a=%h keep_a=%h user_a=%h drop=%h required all 0",
               s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tuser_a, cc_drop_cnt);
    end
    @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    repeat (2) @(negedge user_clk);
    n_cmp++;
    if (s_axis_cc_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b required 1", s_axis_cc_tready);
    end
    @(posedge user_clk);
    #1;
  endtask

  task automatic test_single();
    s_axis_cc_tready_a = 4'hF;
    cap_q.delete();
    cap_cyc.delete();
    send_beat(S1_IN, 16'hFFFF, 1'b1, 4'h0);
    s_axis_cc_tvalid = 1'b0;
    @(negedge user_clk);
    n_cmp++;
    if (s_axis_cc_tvalid_a !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: tvalid_a got %b required 1", s_axis_cc_tvalid_a);
    end
    n_cmp++;
    if ({s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a} !==
        {S1_OUT, 4'hF, 1'b1, 33'h0}) begin
      n_bad++;
      $display("FAIL single_beat: got %h/%h/%b/%h required %h/f/1/0", s_axis_cc_tdata_a,
               s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a, S1_OUT);
    end
    @(negedge user_clk);
    n_cmp++;
    if (s_axis_cc_tvalid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pop: tvalid_a got %b required 0", s_axis_cc_tvalid_a);
    end
    idle(1);
  endtask

  task automatic test_toggle_ready();
    beat_t exp[3];
    beat_t got;
    beat_t cur;
    beat_t prev_b = '0;
    bit    prev_stall = 1'b0;
    int    base_in;
    int    base_out;
    int    occ;
    exp[0] = {{32'h11111111, 32'h00020005, 32'h01000008, 32'h00200000}, 4'hF, 1'b0, 33'h0};
    exp[1] = {{32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222}, 4'hF, 1'b0, 33'h0};
    exp[2] = {{32'h00000000, 32'h88888888, 32'h77777777, 32'h66666666}, 4'h7, 1'b1, 33'h1};
    cap_q.delete();
    cap_cyc.delete();
    base_in  = in_cnt;
    base_out = out_cnt;
    fork
      begin
        send_beat({32'h11111111, 32'h01000500, 32'h02000020, 32'h4A000008}, 16'hFFFF, 1'b0, 4'h0);
        send_beat({32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222}, 16'hFFFF, 1'b0, 4'h0);
        send_beat({32'h00000000, 32'h88888888, 32'h77777777, 32'h66666666}, 16'h0FFF, 1'b1, 4'h8);
        s_axis_cc_tvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          s_axis_cc_tready_a = {3'b111, (i % 2 == 0)};
          @(posedge user_clk);
          #1;
        end
        s_axis_cc_tready_a = 4'hF;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge user_clk);
          occ = (in_cnt - base_in) - (out_cnt - base_out);
          cur = {s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a};
          n_cmp++;
          if (s_axis_cc_tready !== (occ < 2)) begin
            n_bad++;
            $display("FAIL toggle_ready_full: tready got %b with %0d buffered", s_axis_cc_tready, occ);
          end
          if (prev_stall) begin
            n_cmp++;
            if (s_axis_cc_tvalid_a !== 1'b1 || cur !== prev_b) begin
              n_bad++;
              $display("FAIL toggle_stall_stable: got %b/%h required 1/%h", s_axis_cc_tvalid_a, cur, prev_b);
            end
          end
          prev_stall = s_axis_cc_tvalid_a && !s_axis_cc_tready_a[0];
          prev_b     = cur;
        end
      end
    join
    idle(4);
    n_cmp++;
    if (cap_q.size() != 3) begin
      n_bad++;
      $display("FAIL toggle_count: got %0d beats required 3", cap_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL toggle_beat%0d: got %h required %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_one_desc(input string name, input logic [127:0] d, input logic [15:0] k,
                               input logic [3:0] u, input beat_t exp);
    beat_t got;
    cap_q.delete();
    cap_cyc.delete();
    s_axis_cc_tready_a = 4'hF;
    send_beat(d, k, 1'b1, u);
    idle(3);
    got = (cap_q.size() > 0) ? cap_q[0] : '0;
    n_cmp++;
    if (cap_q.size() != 1 || got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d beats, first %h required 1 beat %h", name, cap_q.size(), got, exp);
    end
  endtask

  task automatic test_drop();
    beat_t got;
    cap_q.delete();
    cap_cyc.delete();
    s_axis_cc_tready_a = 4'hF;
    send_beat({32'h12345678, 32'h00001000, 32'h010000FF, 32'h40000004}, 16'hFFFF, 1'b0, 4'h0);
    send_beat({32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 16'hFFFF, 1'b0, 4'h0);
    n_cmp++;
    if (s_axis_cc_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_ready: tready got %b required 1", s_axis_cc_tready);
    end
    send_beat({32'h00000000, 32'h00000000, 32'h00000000, 32'hEEEEEEEE}, 16'h000F, 1'b1, 4'h0);
    idle(3);
    n_cmp++;
    if (cap_q.size() != 0) begin
      n_bad++;
      $display("FAIL drop_no_output: got %0d beats required 0", cap_q.size());
    end
    n_cmp++;
    if (cc_drop_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL drop_count: got %0d required 1", cc_drop_cnt);
    end
    send_beat(S1_IN, 16'hFFFF, 1'b1, 4'h0);
    idle(3);
    got = (cap_q.size() > 0) ? cap_q[0] : '0;
    n_cmp++;
    if (cap_q.size() != 1 || got !== {S1_OUT, 4'hF, 1'b1, 33'h0}) begin
      n_bad++;
      $display("FAIL drop_then_cpld: got %0d beats, first %h", cap_q.size(), got);
    end
  endtask

  task automatic test_back_to_back();
    beat_t exp[4];
    beat_t got;
    exp[0] = {S1_OUT, 4'hF, 1'b1, 33'h0};
    exp[1] = {{32'h11111111, 32'h00020005, 32'h01000008, 32'h00200000}, 4'hF, 1'b0, 33'h0};
    exp[2] = {{32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222}, 4'hF, 1'b0, 33'h0};
    exp[3] = {{32'h00000000, 32'h88888888, 32'h77777777, 32'h66666666}, 4'h7, 1'b1, 33'h0};
    cap_q.delete();
    cap_cyc.delete();
    s_axis_cc_tready_a = 4'hF;
    send_beat(S1_IN, 16'hFFFF, 1'b1, 4'h0);
    send_beat({32'h11111111, 32'h01000500, 32'h02000020, 32'h4A000008}, 16'hFFFF, 1'b0, 4'h0);
    send_beat({32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222}, 16'hFFFF, 1'b0, 4'h0);
    send_beat({32'h00000000, 32'h88888888, 32'h77777777, 32'h66666666}, 16'h0FFF, 1'b1, 4'h0);
    idle(4);
    n_cmp++;
    if (cap_q.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d beats required 4", cap_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got %h required %h", i, got, exp[i]);
      end
      if (i > 0 && i < cap_q.size()) begin
        n_cmp++;
        if (cap_cyc[i] - cap_cyc[i-1] != 1) begin
          n_bad++;
          $display("FAIL b2b_gap%0d: got %0d cycles required 1", i, cap_cyc[i] - cap_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    beat_t got;
    cap_q.delete();
    cap_cyc.delete();
    s_axis_cc_tready_a = 4'hE;
    send_beat({32'h11111111, 32'h01000500, 32'h02000020, 32'h4A000008}, 16'hFFFF, 1'b0, 4'h0);
    send_beat({32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222}, 16'hFFFF, 1'b0, 4'h0);
    s_axis_cc_tvalid = 1'b0;
    user_reset_n = 1'b0;
    @(negedge user_clk);
    n_cmp++;
    if ({s_axis_cc_tvalid_a, s_axis_cc_tlast_a, s_axis_cc_tready} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_outputs: valid_a/last_a/ready got %b%b%b required 000",
               s_axis_cc_tvalid_a, s_axis_cc_tlast_a, s_axis_cc_tready);
    end
    n_cmp++;
    if (cc_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_drop_cnt: got %0d required 0", cc_drop_cnt);
    end
    repeat (2) @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    s_axis_cc_tready_a = 4'hF;
    send_beat(S1_IN, 16'hFFFF, 1'b1, 4'h0);
    idle(3);
    got = (cap_q.size() > 0) ? cap_q[0] : '0;
    n_cmp++;
    if (cap_q.size() != 1 || got !== {S1_OUT, 4'hF, 1'b1, 33'h0}) begin
      n_bad++;
      $display("FAIL rstmid_next: got %0d beats, first %h required 1 beat %h", cap_q.size(), got,
               {S1_OUT, 4'hF, 1'b1, 33'h0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle_ready();
    test_one_desc("cpl_ur", {32'h00000000, 32'h01000700, 32'h02002000, 32'h0A000000}, 16'h0FFF,
                  4'h0, {{32'h00000000, 32'h00020007, 32'h01000800, 32'h10000000}, 4'h7, 1'b1, 33'h0});
    test_one_desc("cpldlk_poison", {32'hCAFEF00D, 32'h01000900, 32'h02000000, 32'h4B302000}, 16'hFFFF,
                  4'h2, {{32'hCAFEF00D, 32'h26020009, 32'h01004400, 32'h30000000}, 4'hF, 1'b1, 33'h0});
    test_drop();
    test_back_to_back();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
